// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and helpers for the packed-BCD to binary converter.
//   bcd_digit_t     : one 4-bit BCD digit
//   bcd_bin_width   : binary width needed to hold any N-digit BCD value
//   bcd_digit_valid : true for digits 0..9
//   b2b_state_t     : converter FSM state encoding
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } b2b_state_t;

  // ceil(log2(10^n)); 10^n is never a power of two, so this is the smallest w
  // with 2^w >= 10^n.
  function automatic int bcd_bin_width(input int n);
    longint p;
    int     w;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    w = 0;
    while ((longint'(1) << w) < p) w++;
    return w;
  endfunction

  function automatic logic bcd_digit_valid(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_rdd_digit_corr.sv
// -----------------------------------------------------------------------------
// bcd_rdd_digit_corr
// Reverse double-dabble correction cell for one BCD digit: a digit that has
// reached 8 or more after the right shift had a borrowed 10 split into 8+2
// halves, so 3 is taken back off (d >= 8 ? d - 3 : d). Purely combinational.
//   d_i : shifted digit
//   d_o : corrected digit
// -----------------------------------------------------------------------------
module bcd_rdd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  localparam bcd_digit_t CORR_THRESH = 4'd8;
  localparam bcd_digit_t CORR_AMOUNT = 4'd3;

  assign d_o = (d_i >= CORR_THRESH) ? (d_i - CORR_AMOUNT) : d_i;

endmodule

// File: rtl/bcd_to_bin_converter.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_converter
// Sequential N-digit packed-BCD to unsigned binary converter (reverse
// double-dabble, one shift + per-digit correction per cycle, W cycles).
//
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous, active-low reset
//   start       : conversion request, sampled only while busy=0
//   bcd_in      : packed BCD operand, digit i at [4i+3:4i]
//   busy        : conversion in progress
//   done        : one-cycle pulse, bin_out/err valid
//   bin_out     : binary result, held until the next done
//   err         : an input digit was > 9 (updated with every done)
//   dbg_state_o : current FSM state (b2b_state_t encoding), for observation
//
// Handshake: a request is taken on any rising edge where start=1 and the
// converter is not busy (state IDLE or DONE). Requests seen while busy=1 are
// dropped, not queued. bcd_in is captured only on that accept edge. Every
// accepted request yields exactly one done pulse unless reset intervenes.
// -----------------------------------------------------------------------------
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter  int N = 3,
  localparam int W = bcd_bin_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4*N-1:0] bcd_in,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   bin_out,
  output logic           err,
  output logic [1:0]     dbg_state_o
);

  localparam int             CW       = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

  b2b_state_t      state_q;
  logic [4*N-1:0]  bcd_sr_q;
  logic [W-1:0]    bin_sr_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [W-1:0]    bin_out_q;

  logic [4*N-1:0]  bcd_shift;
  logic [4*N-1:0]  bcd_sr_d;
  logic [W-1:0]    bin_sr_d;
  logic            in_valid;

  // Right shift of the combined {bcd_sr, bin_sr} register: the BCD LSB falls
  // into the binary MSB, a zero enters the top BCD digit.
  assign bcd_shift = {1'b0, bcd_sr_q[4*N-1:1]};
  assign bin_sr_d  = {bcd_sr_q[0], bin_sr_q[W-1:1]};

  for (genvar g = 0; g < N; g++) begin : g_corr
    bcd_rdd_digit_corr u_corr (
      .d_i (bcd_shift[4*g +: 4]),
      .d_o (bcd_sr_d[4*g +: 4])
    );
  end

  always_comb begin
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (!bcd_digit_valid(bcd_in[4*i +: 4])) in_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts exactly like IDLE so back-to-back requests lose no cycle.
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            if (in_valid) begin
              bcd_sr_q <= bcd_in;
              bin_sr_q <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_CONV;
            end else begin
              // Malformed operand: report immediately, no conversion run.
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              bin_out_q <= '0;
            end
          end
        end
        S_CONV: begin
          bcd_sr_q <= bcd_sr_d;
          bin_sr_q <= bin_sr_d;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            bin_out_q <= bin_sr_d;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bin_out     = bin_out_q;
  assign dbg_state_o = state_q;

endmodule
